// File: rtl/lfsr_pkg.sv
// Shared constants and the feedback helper for the Fibonacci LFSR generator.
package lfsr_pkg;

    localparam int         LFSR_W_DEF     = 4;
    localparam logic [3:0] LFSR_TAPS_DEF  = 4'b1010;
    localparam logic [3:0] LFSR_SEED_DEF  = 4'hE;
    localparam logic [3:0] LFSR4_TAPS_MAX = 4'b1001;

    // Widths up to 32 are handled by zero-extending state and mask.
    function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lock-up recovery and a period
// counter that pulses wrap_o when the state returns to its start value.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_W_DEF,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] lfsr_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "lfsr_gen: WIDTH must be in 2..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $fatal(1, "lfsr_gen: SEED must be non-zero");
        end
        if (TAPS == '0) begin : g_bad_taps
            $fatal(1, "lfsr_gen: TAPS must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;

    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_state_next;
    logic [WIDTH-1:0] w_start_next;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_wrap_next;

    assign w_fb    = lfsr_fb(32'(r_state), 32'(TAPS));
    assign w_shift = {r_state[WIDTH-2:0], w_fb};

    always_comb begin
        w_state_next = r_state;
        w_start_next = r_start;
        w_cnt_next   = r_cnt;
        w_wrap_next  = 1'b0;
        if (load_i) begin
            w_state_next = seed_i;
            w_start_next = seed_i;
            w_cnt_next   = '0;
        end else if (en_i && (r_state == '0)) begin
            // All-zero is a fixed point of the XOR feedback; restart from SEED.
            w_state_next = SEED;
            w_start_next = SEED;
            w_cnt_next   = '0;
        end else if (en_i) begin
            w_state_next = w_shift;
            if (w_shift == r_start) begin
                w_wrap_next = 1'b1;
                w_cnt_next  = '0;
            end else begin
                w_cnt_next  = r_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
            r_start <= SEED;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_start_next;
            r_cnt   <= w_cnt_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign lfsr_o   = r_state;
    assign cnt_o    = r_cnt;
    assign wrap_o   = r_wrap;
    assign lockup_o = (r_state == '0);

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 6-step sequence, maximal-length
// 4-bit sequence, lock-up recovery, load priority/hold and async reset.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_i;
    logic       load_i;
    logic [3:0] seed_i;

    logic [3:0] d_lfsr, d_cnt;
    logic       d_wrap, d_lock;
    logic [3:0] m_lfsr, m_cnt;
    logic       m_wrap, m_lock;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_gen dut_d (
        .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i), .seed_i(seed_i),
        .lfsr_o(d_lfsr), .cnt_o(d_cnt), .wrap_o(d_wrap), .lockup_o(d_lock)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'hE)) dut_m (
        .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i), .seed_i(seed_i),
        .lfsr_o(m_lfsr), .cnt_o(m_cnt), .wrap_o(m_wrap), .lockup_o(m_lock)
    );

    task automatic do_reset();
        en_i = 1'b0; load_i = 1'b0; seed_i = 4'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({d_lfsr, d_cnt, d_wrap, d_lock} !== {4'hE, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: lfsr=%h cnt=%h wrap=%b lock=%b, required E 0 0 0",
                     d_lfsr, d_cnt, d_wrap, d_lock);
        end
        $display("reset: lfsr=%h cnt=%h wrap=%b lock=%b", d_lfsr, d_cnt, d_wrap, d_lock);
    endtask

    task automatic test_default_seq();
        logic [3:0] exp_s [6] = '{4'hC, 4'h9, 4'h3, 4'h7, 4'hF, 4'hE};
        logic [3:0] exp_c [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        logic       exp_w [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({d_lfsr, d_cnt, d_wrap} !== {exp_s[i], exp_c[i], exp_w[i]}) begin
                n_err++;
                $display("FAIL default_seq[%0d]: lfsr=%h cnt=%0d wrap=%b, required %h %0d %b",
                         i, d_lfsr, d_cnt, d_wrap, exp_s[i], exp_c[i], exp_w[i]);
            end
            $display("default_seq[%0d]: lfsr=%h cnt=%0d wrap=%b", i, d_lfsr, d_cnt, d_wrap);
        end
        en_i = 1'b0;
    endtask

    task automatic test_maxlen();
        logic [3:0] exp_s [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                                   4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
        logic [3:0] exp_c;
        logic       exp_w;
        int         wraps = 0;
        do_reset();
        load_i = 1'b1; seed_i = 4'h1;
        @(posedge clk); #1;
        load_i = 1'b0;
        n_cmp++;
        if ({m_lfsr, m_cnt, m_wrap} !== {4'h1, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL maxlen_load: lfsr=%h cnt=%0d wrap=%b, required 1 0 0", m_lfsr, m_cnt, m_wrap);
        end
        en_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            exp_w = (i == 14);
            exp_c = exp_w ? 4'd0 : 4'(i + 1);
            if (m_wrap) wraps++;
            n_cmp++;
            if ({m_lfsr, m_cnt, m_wrap} !== {exp_s[i], exp_c, exp_w}) begin
                n_err++;
                $display("FAIL maxlen[%0d]: lfsr=%h cnt=%0d wrap=%b, required %h %0d %b",
                         i, m_lfsr, m_cnt, m_wrap, exp_s[i], exp_c, exp_w);
            end
            $display("maxlen[%0d]: lfsr=%h cnt=%0d wrap=%b", i, m_lfsr, m_cnt, m_wrap);
        end
        en_i = 1'b0;
        n_cmp++;
        if (wraps !== 1) begin
            n_err++;
            $display("FAIL maxlen_wraps: counted %0d, required 1", wraps);
        end
    endtask

    task automatic test_lockup();
        do_reset();
        load_i = 1'b1; seed_i = 4'h0;
        @(posedge clk); #1;
        load_i = 1'b0;
        n_cmp++;
        if ({d_lfsr, d_lock} !== {4'h0, 1'b1}) begin
            n_err++;
            $display("FAIL lockup_enter: lfsr=%h lock=%b, required 0 1", d_lfsr, d_lock);
        end
        $display("lockup_enter: lfsr=%h lock=%b", d_lfsr, d_lock);
        en_i = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        n_cmp++;
        if ({d_lfsr, d_cnt, d_wrap, d_lock} !== {4'hE, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL lockup_recover: lfsr=%h cnt=%0d wrap=%b lock=%b, required E 0 0 0",
                     d_lfsr, d_cnt, d_wrap, d_lock);
        end
        $display("lockup_recover: lfsr=%h cnt=%0d lock=%b", d_lfsr, d_cnt, d_lock);
    endtask

    task automatic test_priority_hold();
        do_reset();
        en_i = 1'b1;
        @(posedge clk); #1;
        load_i = 1'b1; seed_i = 4'h5;
        @(posedge clk); #1;
        load_i = 1'b0;
        n_cmp++;
        if ({d_lfsr, d_cnt, d_wrap} !== {4'h5, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL priority: lfsr=%h cnt=%0d wrap=%b, required 5 0 0", d_lfsr, d_cnt, d_wrap);
        end
        $display("priority: lfsr=%h cnt=%0d", d_lfsr, d_cnt);
        @(posedge clk); #1;
        en_i = 1'b0;
        n_cmp++;
        if ({d_lfsr, d_cnt} !== {4'hA, 4'h1}) begin
            n_err++;
            $display("FAIL step_after_load: lfsr=%h cnt=%0d, required A 1", d_lfsr, d_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({d_lfsr, d_cnt, d_wrap} !== {4'hA, 4'h1, 1'b0}) begin
                n_err++;
                $display("FAIL hold[%0d]: lfsr=%h cnt=%0d wrap=%b, required A 1 0",
                         i, d_lfsr, d_cnt, d_wrap);
            end
        end
        $display("hold: lfsr=%h cnt=%0d after 10 idle cycles", d_lfsr, d_cnt);
    endtask

    task automatic test_mid_reset();
        do_reset();
        en_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        en_i = 1'b0;
        n_cmp++;
        if ({d_lfsr, d_cnt} !== {4'h3, 4'h3}) begin
            n_err++;
            $display("FAIL pre_reset: lfsr=%h cnt=%0d, required 3 3", d_lfsr, d_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({d_lfsr, d_cnt, d_wrap, d_lock} !== {4'hE, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: lfsr=%h cnt=%0d wrap=%b lock=%b, required E 0 0 0",
                     d_lfsr, d_cnt, d_wrap, d_lock);
        end
        $display("async_reset: lfsr=%h cnt=%0d", d_lfsr, d_cnt);
        @(negedge clk);
        reset = 1'b0;
        en_i  = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        n_cmp++;
        if ({d_lfsr, d_cnt} !== {4'hC, 4'h1}) begin
            n_err++;
            $display("FAIL restart: lfsr=%h cnt=%0d, required C 1", d_lfsr, d_cnt);
        end
        $display("restart: lfsr=%h cnt=%0d", d_lfsr, d_cnt);
    endtask

    initial begin
        reset = 1'b1; en_i = 1'b0; load_i = 1'b0; seed_i = 4'h0;
        test_reset();
        test_default_seq();
        test_maxlen();
        test_lockup();
        test_priority_hold();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
